// File: rtl/fp8_mac_pkg.sv
// fp8_mac_pkg: shared FP8/FP12 formats, operand classes and pipeline payloads
package fp8_mac_pkg;
  localparam int EXP_BIAS = 7;
  localparam int EXP_W = 4;
  localparam int IN_MAN_W = 3;
  localparam int OUT_MAN_W = 2 * IN_MAN_W + 1;
  localparam int FP8_W = 1 + EXP_W + IN_MAN_W;
  localparam int FP12_W = 1 + EXP_W + OUT_MAN_W;
  localparam logic [FP12_W-1:0] FP12_NAN = 12'h7C0;
  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;
  typedef struct packed {
    logic s;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [IN_MAN_W:0] ma;
    logic [IN_MAN_W:0] mb;
    cls_e ca;
    cls_e cb;
    logic sub;
  } dec_t;
  typedef struct packed {
    logic s;
    logic [2*IN_MAN_W+1:0] p;
    logic signed [5:0] esum;
    cls_e cls;
    logic sub;
  } mul_t;
  typedef struct packed {
    logic [2:0] flags;
    logic [FP12_W-1:0] fp12;
  } out_t;
  // Subnormals are classed as zero; the caller flags them separately
  function automatic cls_e classify(input logic [FP8_W-2:0] x);
    return x[6:3] == 4'h0 ? CLS_ZERO : x[6:3] == 4'hF ? (x[2:0] == 3'h0 ? CLS_INF : CLS_NAN) : CLS_NORM;
  endfunction
endpackage

// File: rtl/fp_pipe_reg.sv
// fp_pipe_reg: elastic valid/ready register slice holding one data word
module fp_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);
  logic valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o = data_q;
  always_comb begin
    valid_d = ready_o ? valid_i : valid_q;
    data_d = ready_o && valid_i ? data_i : data_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/fp8_e4m3_mul_pipe.sv
// fp8_e4m3_mul_pipe: 3-stage elastic E4M3 x E4M3 -> FP12 multiplier (exact, no rounding)
// Decode, multiply and normalise/pack sit combinationally in front of each register slice.
module fp8_e4m3_mul_pipe
  import fp8_mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a_fp8,
  input  logic [7:0]  b_fp8,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] fp12_out,
  output logic [2:0]  out_flags
);
  dec_t dec, d1;
  mul_t mul, d2;
  out_t pk, d3;
  logic v1, v2, r1, r2, r3;
  logic [6:0] man;
  logic signed [5:0] e;
  logic nan_r, inf_r, zero_r;
  always_comb begin
    dec.s = a_fp8[7] ^ b_fp8[7];
    dec.ea = a_fp8[6:3];
    dec.eb = b_fp8[6:3];
    dec.ma = {1'b1, a_fp8[2:0]};
    dec.mb = {1'b1, b_fp8[2:0]};
    dec.ca = classify(a_fp8[6:0]);
    dec.cb = classify(b_fp8[6:0]);
    dec.sub = (a_fp8[6:3] == 4'h0 && a_fp8[2:0] != 3'h0) || (b_fp8[6:3] == 4'h0 && b_fp8[2:0] != 3'h0);
  end
  assign nan_r = d1.ca == CLS_NAN || d1.cb == CLS_NAN || (d1.ca == CLS_INF && d1.cb == CLS_ZERO) || (d1.ca == CLS_ZERO && d1.cb == CLS_INF);
  assign inf_r = d1.ca == CLS_INF || d1.cb == CLS_INF;
  assign zero_r = d1.ca == CLS_ZERO || d1.cb == CLS_ZERO;
  always_comb begin
    mul.s = d1.s;
    mul.p = {4'h0, d1.ma} * {4'h0, d1.mb};
    mul.esum = 6'(d1.ea) + 6'(d1.eb) - 6'(EXP_BIAS);
    mul.cls = nan_r ? CLS_NAN : inf_r ? CLS_INF : zero_r ? CLS_ZERO : CLS_NORM;
    mul.sub = d1.sub;
  end
  // Product of two [1,2) significands lies in [1,4): at most one right shift
  always_comb begin
    man = d2.p[7] ? d2.p[6:0] : {d2.p[5:0], 1'b0};
    e = d2.p[7] ? d2.esum + 6'sd1 : d2.esum;
    pk.fp12 = d2.cls == CLS_NAN ? FP12_NAN :
              d2.cls == CLS_INF ? {d2.s, 4'hF, 7'h0} :
              d2.cls == CLS_ZERO ? {d2.s, 11'h0} :
              e >= 6'sd15 ? {d2.s, 4'hF, 7'h0} :
              e <= 6'sd0 ? {d2.s, 11'h0} : {d2.s, e[3:0], man};
    pk.flags = d2.cls == CLS_NAN ? 3'b100 :
               d2.cls == CLS_INF ? 3'b000 :
               d2.cls == CLS_ZERO ? {2'b00, d2.sub} :
               e >= 6'sd15 ? 3'b010 :
               e <= 6'sd0 ? 3'b001 : 3'b000;
  end
  assign in_ready = rst_n && r1;
  fp_pipe_reg #(.W($bits(dec_t))) u_s1 (
    .clk(clk), .rst_n(rst_n), .valid_i(in_valid), .ready_o(r1), .data_i(dec),
    .valid_o(v1), .ready_i(r2), .data_o(d1)
  );
  fp_pipe_reg #(.W($bits(mul_t))) u_s2 (
    .clk(clk), .rst_n(rst_n), .valid_i(v1), .ready_o(r2), .data_i(mul),
    .valid_o(v2), .ready_i(r3), .data_o(d2)
  );
  fp_pipe_reg #(.W($bits(out_t))) u_s3 (
    .clk(clk), .rst_n(rst_n), .valid_i(v2), .ready_o(r3), .data_i(pk),
    .valid_o(out_valid), .ready_i(out_ready), .data_o(d3)
  );
  assign fp12_out = d3.fp12;
  assign out_flags = d3.flags;
endmodule

// File: tb/tb_fp8_e4m3_mul_pipe.sv
// tb_fp8_e4m3_mul_pipe: directed and randomized checks of the FP8 multiplier pipeline
// Expected results come from a real-valued model of the E4M3/FP12 formats.
module tb_fp8_e4m3_mul_pipe;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a_fp8, b_fp8;
  logic [11:0] fp12_out;
  logic [2:0] out_flags;
  int errors = 0, checks = 0, nout = 0, spurious = 0, cycle = 0;
  logic [14:0] exp_q[$];
  bit hold = 0, in_fired, out_fired;
  logic [14:0] held;

  fp8_e4m3_mul_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_fp8(a_fp8), .b_fp8(b_fp8), .out_valid(out_valid), .out_ready(out_ready),
    .fp12_out(fp12_out), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic real pow2(int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  // Returns {flags, fp12} from the numeric value of the operands
  function automatic logic [14:0] model(logic [7:0] a, logic [7:0] b);
    int ea = int'(a[6:3]), eb = int'(b[6:3]), ma = int'(a[2:0]), mb = int'(b[2:0]), e = 7, frac;
    bit s = a[7] ^ b[7];
    bit az = ea == 0, bz = eb == 0;
    bit ai = ea == 15 && ma == 0, bi = eb == 15 && mb == 0;
    bit an = ea == 15 && ma != 0, bn = eb == 15 && mb != 0;
    real x;
    if (an || bn || (ai && bz) || (az && bi)) return {3'b100, 12'h7C0};
    if (ai || bi) return {3'b000, s, 4'hF, 7'h0};
    if (az || bz) return {2'b00, (az && ma != 0) || (bz && mb != 0), s, 11'h0};
    x = (1.0 + ma / 8.0) * pow2(ea - 7) * (1.0 + mb / 8.0) * pow2(eb - 7);
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0) begin x = x * 2.0; e--; end
    frac = int'((x - 1.0) * 128.0);
    if (e >= 15) return {3'b010, s, 4'hF, 7'h0};
    if (e <= 0) return {3'b001, s, 11'h0};
    return {3'b000, s, 4'(e), 7'(frac)};
  endfunction

  // One clock: sample handshakes at negedge, score them, then step past posedge
  task automatic cyc();
    @(negedge clk);
    if (hold) chk("stall_stable", {out_valid, out_flags, fp12_out}, {1'b1, held});
    hold = out_valid && !out_ready;
    held = {out_flags, fp12_out};
    in_fired = in_valid && in_ready;
    out_fired = out_valid && out_ready;
    if (out_fired) begin
      nout++;
      if (exp_q.size() == 0) spurious++;
      else chk("stream", {17'h0, out_flags, fp12_out}, {17'h0, exp_q.pop_front()});
    end
    if (in_fired) exp_q.push_back(model(a_fp8, b_fp8));
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic single(logic [7:0] a, logic [7:0] b, logic [11:0] ef, logic [2:0] eg);
    int lat;
    a_fp8 = a;
    b_fp8 = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 3);
    chk("dir_fp12", fp12_out, ef);
    chk("dir_flags", out_flags, eg);
    @(posedge clk);
    #1;
  endtask

  logic [7:0] da[8] = '{8'h38, 8'h3C, 8'hBC, 8'h77, 8'h08, 8'h78, 8'h79, 8'h78};
  logic [7:0] db[8] = '{8'h38, 8'h3C, 8'h3C, 8'h77, 8'h08, 8'h00, 8'h38, 8'h38};
  logic [11:0] dp[8] = '{12'h380, 12'h410, 12'hC10, 12'h780, 12'h000, 12'h7C0, 12'h7C0, 12'h780};
  logic [2:0] dfl[8] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b100, 3'b100, 3'b000};
  logic [7:0] sa[4] = '{8'h3C, 8'h38, 8'hBC, 8'h44};
  logic [7:0] sb[4] = '{8'h3C, 8'h38, 8'h3C, 8'h2A};

  initial begin
    int idx, base, first, last, guard;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_fp8 = 8'h0;
    b_fp8 = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fp12", fp12_out, 0);
    chk("rst_flags", out_flags, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_idle", in_ready, 1);
    for (int i = 0; i < 8; i++) single(da[i], db[i], dp[i], dfl[i]);
    chk("idle_after_dir", out_valid, 0);

    // Stream of 4 ops against a 5-cycle output stall
    out_ready = 1'b0;
    idx = 0;
    base = nout;
    a_fp8 = sa[0];
    b_fp8 = sb[0];
    in_valid = 1'b1;
    repeat (5) begin
      cyc();
      if (in_fired) idx++;
      if (idx < 4) begin a_fp8 = sa[idx]; b_fp8 = sb[idx]; end
      else in_valid = 1'b0;
    end
    chk("stall_accepted", idx, 3);
    chk("stall_in_ready", in_ready, 0);
    chk("stall_out_valid", out_valid, 1);
    out_ready = 1'b1;
    first = -1;
    last = -1;
    guard = 0;
    while (nout < base + 4 && guard < 20) begin
      cyc();
      guard++;
      if (in_fired) idx++;
      if (idx < 4) begin a_fp8 = sa[idx]; b_fp8 = sb[idx]; end
      else in_valid = 1'b0;
      if (out_fired) begin
        if (first < 0) first = cycle;
        last = cycle;
      end
    end
    chk("stall_count", nout - base, 4);
    chk("stall_no_gaps", last - first, 3);

    // Reset with three operations in flight
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (4) begin
      a_fp8 = 8'($urandom);
      b_fp8 = 8'($urandom);
      cyc();
    end
    chk("full_before_rst", out_valid, 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_fp12", fp12_out, 0);
    chk("rst2_flags", out_flags, 0);
    chk("rst2_in_ready", in_ready, 0);
    rst_n = 1'b1;
    exp_q.delete();
    hold = 0;
    out_ready = 1'b1;
    base = nout;
    repeat (6) cyc();
    chk("no_stale", nout - base, 0);

    // Randomized traffic with random backpressure
    repeat (400) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      a_fp8 = 8'($urandom);
      b_fp8 = 8'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) cyc();
    chk("drained", exp_q.size(), 0);
    chk("spurious", spurious, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
